booth_r4_seq_mult: RTL

- Sequential signed radix-4 Booth multiplier controller for the DNN multiply path.
- Accepts one operand pair over a valid/ready handshake.
- Steps through the multiplier one 3-bit Booth window per cycle, forming one partial product per step and accumulating it.
- Returns the 2*WIDTH-bit product over a second valid/ready handshake.
- Intended as the time-multiplexed alternative to the parallel Booth array in the approximate-multiplier study.

---
 rtl/booth_r4_seq_mult_if.sv | 27 ++
 rtl/booth_r4_seq_mult.sv | 137 +++++++++++++
 2 files changed

// File: rtl/booth_r4_seq_mult_if.sv
// Operand/product handshake bundle for booth_r4_seq_mult.
// Zero latency: wires only, no storage.
// Both directions use valid/ready. The producer holds its data stable until ready is seen.
interface booth_r4_seq_mult_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  // Requester side: offers operands and consumes the product.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  // Multiplier side.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth_r4_seq_mult.sv
// Sequential signed radix-4 Booth multiplier. It retires one 3-bit Booth window per cycle.
// Latency: out_valid rises WIDTH/2 cycles after the operand-accept edge.
//   Throughput is one result every WIDTH/2+2 cycles.
// Backpressure: the DONE state holds the product until out_ready. in_ready stays low while busy.
// Optional macro BOOTH_APPROX_TRUNC_EN clears bits [TRUNC_BITS-1:0] of every aligned partial product.
module booth_r4_seq_mult #(
  parameter int WIDTH      = 8,
  parameter int TRUNC_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  booth_r4_seq_mult_if.slave    io
);

  localparam int PW    = 2 * WIDTH;
  localparam int STEPS = WIDTH / 2;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  // Reject parameter sets that the datapath cannot represent.
  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4 || TRUNC_BITS < 0 || TRUNC_BITS >= PW) begin : g_bad_params
      $error("booth_r4_seq_mult: illegal WIDTH/TRUNC_BITS combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  // The multiplicand is kept pre-aligned. It shifts left by 2 each step,
  // so the partial product is already weighted by 4^i.
  logic [PW-1:0]    mcand_q, mcand_d;
  // The Booth register holds {b,1'b0}. It shifts right by 2 each step,
  // so the current window is always bits [2:0].
  logic [WIDTH:0]   mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    product_q, product_d;

  logic [2:0]       window;
  logic [PW-1:0]    pp_raw;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    acc_sum;

  assign window = mplier_q[2:0];

  // Booth digit decode: select 0, +/-A or +/-2A for the current window.
  always_comb begin
    pp_raw = '0;
    unique case (window)
      3'b001, 3'b010: pp_raw = mcand_q;
      3'b011:         pp_raw = mcand_q << 1;
      3'b100:         pp_raw = -(mcand_q << 1);
      3'b101, 3'b110: pp_raw = -mcand_q;
      default:        pp_raw = '0;
    endcase
  end

`ifdef BOOTH_APPROX_TRUNC_EN
  // Low-bit truncation of each aligned partial product.
  // The mask is a constant, so later steps are unaffected because their low bits are already zero.
  localparam logic [PW-1:0] TRUNC_MASK = ~((PW'(1) << TRUNC_BITS) - PW'(1));
  assign pp = pp_raw & TRUNC_MASK;
`else
  assign pp = pp_raw;
`endif

  assign acc_sum = acc_q + pp;

  // Next-state and datapath control for the IDLE -> CALC -> DONE sequence.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      ST_IDLE: begin
        if (io.in_valid) begin
          mcand_d  = {{WIDTH{io.a[WIDTH-1]}}, io.a};
          mplier_d = {io.b, 1'b0};
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 2;
        mplier_d = {2'b00, mplier_q[WIDTH:2]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          product_d = acc_sum;
          cnt_d     = '0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (io.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers. Reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign io.in_ready  = (state_q == ST_IDLE);
  assign io.out_valid = (state_q == ST_DONE);
  assign io.busy      = (state_q != ST_IDLE);
  assign io.product   = product_q;

endmodule
